// File: rtl/vga_sync_gen_if.sv
// Pixel-timing bundle between the VGA sync generator (master) and its consumers (slave).
interface vga_sync_gen_if;
    logic       en;
    logic       p_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_end;

    modport master (
        input  en,
        output p_tick, pix_x, pix_y, hsync, vsync, video_on, frame_end
    );

    modport slave (
        output en,
        input  p_tick, pix_x, pix_y, hsync, vsync, video_on, frame_end
    );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA timing source: pixel-enable divider, H/V counters, sync/visible/frame flags.
// Optional macro SYNC_DELAY_EN delays HSYNC/VSYNC/VIDEO_ON by one pixel to match renderer latency.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    function automatic logic hsync_of(input logic [9:0] x);
        hsync_of = !((x >= HS_FIRST) && (x <= HS_LAST));
    endfunction

    function automatic logic vsync_of(input logic [9:0] y);
        vsync_of = !((y >= VS_FIRST) && (y <= VS_LAST));
    endfunction

    function automatic logic video_of(input logic [9:0] x, input logic [9:0] y);
        video_of = (x < H_VIS) && (y < V_VIS);
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             p_tick_q, p_tick_d;
    logic [9:0]       pix_x_q, pix_x_d;
    logic [9:0]       pix_y_q, pix_y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             frame_end_q, frame_end_d;
    logic             tick_s;

    // Divider and counter next-state; sync flags follow the next count so they never lag it.
    always_comb begin
        tick_s      = 1'b0;
        div_cnt_d   = div_cnt_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        if (vga.en) begin
            if (div_cnt_q >= DIV_LAST) begin
                div_cnt_d = '0;
                tick_s    = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end
        end else begin
            div_cnt_d = div_cnt_q;
        end

        // >= instead of == keeps the counters self-recovering into the legal range.
        if (tick_s) begin
            if (pix_x_q >= H_LAST) begin
                pix_x_d = 10'd0;
                if (pix_y_q >= V_LAST) begin
                    pix_y_d = 10'd0;
                end else begin
                    pix_y_d = pix_y_q + 10'd1;
                end
            end else begin
                pix_x_d = pix_x_q + 10'd1;
            end
        end else begin
            pix_x_d = pix_x_q;
            pix_y_d = pix_y_q;
        end

        p_tick_d    = tick_s;
        frame_end_d = tick_s && (pix_x_d == 10'd0) && (pix_y_d == 10'd0);
        hsync_d     = hsync_of(pix_x_d);
        vsync_d     = vsync_of(pix_y_d);
        video_on_d  = video_of(pix_x_d, pix_y_d);
    end

    // Timing state registers; reset parks the counters on the last pixel of the frame.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_q   <= '0;
            p_tick_q    <= 1'b0;
            pix_x_q     <= H_LAST;
            pix_y_q     <= V_LAST;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            video_on_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            p_tick_q    <= p_tick_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_on_q  <= video_on_d;
            frame_end_q <= frame_end_d;
        end
    end

`ifdef SYNC_DELAY_EN
    logic hsync_dly_q, hsync_dly_d;
    logic vsync_dly_q, vsync_dly_d;
    logic video_on_dly_q, video_on_dly_d;

    // Delay stage captures the outgoing pixel's flags on each tick.
    always_comb begin
        hsync_dly_d    = hsync_dly_q;
        vsync_dly_d    = vsync_dly_q;
        video_on_dly_d = video_on_dly_q;
        if (tick_s) begin
            hsync_dly_d    = hsync_q;
            vsync_dly_d    = vsync_q;
            video_on_dly_d = video_on_q;
        end else begin
            hsync_dly_d    = hsync_dly_q;
            vsync_dly_d    = vsync_dly_q;
            video_on_dly_d = video_on_dly_q;
        end
    end

    // One-pixel delay registers for the sync and visible flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hsync_dly_q    <= 1'b1;
            vsync_dly_q    <= 1'b1;
            video_on_dly_q <= 1'b0;
        end else begin
            hsync_dly_q    <= hsync_dly_d;
            vsync_dly_q    <= vsync_dly_d;
            video_on_dly_q <= video_on_dly_d;
        end
    end

    assign vga.hsync    = hsync_dly_q;
    assign vga.vsync    = vsync_dly_q;
    assign vga.video_on = video_on_dly_q;
`else
    assign vga.hsync    = hsync_q;
    assign vga.vsync    = vsync_q;
    assign vga.video_on = video_on_q;
`endif

    assign vga.p_tick    = p_tick_q;
    assign vga.pix_x     = pix_x_q;
    assign vga.pix_y     = pix_y_q;
    assign vga.frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a full-size instance and a tiny-frame instance share EN/reset.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       fe;
    } obs_t;

    localparam int D_DIV = 4;
    localparam int S_DIV = 3;

    logic clk;
    logic rst_n;
    logic en;

    int   errors;
    int   checks;
    int   e_cnt;
    int   n_cnt [2];
    obs_t q0 [$];
    obs_t q1 [$];
    obs_t last [2];

    vga_sync_gen_if vga0 ();
    vga_sync_gen_if vga1 ();

    assign vga0.en = en;
    assign vga1.en = en;

    vga_sync_gen dut0 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .vga     (vga0)
    );

    vga_sync_gen #(
        .CLK_DIV(S_DIV), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .vga     (vga1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: after n ticks the beam sits at linear pixel (frame-1+n) mod frame.
    function automatic obs_t ref_model(input int i, input int n);
        int hv, hf, hsw, hb, vv, vf, vsw, vb;
        int ht, vt, fr, p, q, xq, yq;
        obs_t r;
        if (i == 0) begin
            hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33;
        end else begin
            hv = 8; hf = 2; hsw = 3; hb = 2; vv = 4; vf = 1; vsw = 2; vb = 1;
        end
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        fr = ht * vt;
        p  = (fr - 1 + n) % fr;
`ifdef SYNC_DELAY_EN
        q  = (fr - 2 + n) % fr;
`else
        q  = p;
`endif
        xq   = q % ht;
        yq   = q / ht;
        r.x  = 10'(p % ht);
        r.y  = 10'(p / ht);
        r.fe = (n > 0) && (p == 0);
        r.hs = !((xq >= hv + hf) && (xq < hv + hf + hsw));
        r.vs = !((yq >= vv + vf) && (yq < vv + vf + vsw));
        r.vo = (xq < hv) && (yq < vv);
        return r;
    endfunction

    function automatic obs_t reset_obs(input int i);
        obs_t r;
        r.x  = (i == 0) ? 10'd799 : 10'd14;
        r.y  = (i == 0) ? 10'd524 : 10'd7;
        r.hs = 1'b1;
        r.vs = 1'b1;
        r.vo = 1'b0;
        r.fe = 1'b0;
        return r;
    endfunction

    function automatic obs_t sample(input int i);
        if (i == 0)
            return {vga0.pix_x, vga0.pix_y, vga0.hsync, vga0.vsync, vga0.video_on, vga0.frame_end};
        else
            return {vga1.pix_x, vga1.pix_y, vga1.hsync, vga1.vsync, vga1.video_on, vga1.frame_end};
    endfunction

    task automatic report(input string name, input int i, input logic tk, input obs_t a, input obs_t r);
        $display("FAIL %s inst%0d: got tick=%0b x=%0d y=%0d hs=%0b vs=%0b vo=%0b fe=%0b, want x=%0d y=%0d hs=%0b vs=%0b vo=%0b fe=%0b",
                 name, i, tk, a.x, a.y, a.hs, a.vs, a.vo, a.fe, r.x, r.y, r.hs, r.vs, r.vo, r.fe);
    endtask

    // Monitor: pop an expectation on each presented tick, otherwise require held outputs.
    task automatic mon(input int i, input logic tk);
        obs_t exp_o;
        obs_t act;
        bit   have;
        have  = 1'b0;
        exp_o = last[i];
        exp_o.fe = 1'b0;
        if (i == 0 && q0.size() > 0) begin
            exp_o = q0.pop_front();
            have  = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
            exp_o = q1.pop_front();
            have  = 1'b1;
        end
        act = sample(i);
        checks++;
        if (tk !== have || act !== exp_o) begin
            errors++;
            report(have ? "tick_out" : "hold_out", i, tk, act, exp_o);
        end
        if (have) last[i] = exp_o;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last[0] = reset_obs(0);
            last[1] = reset_obs(1);
        end else begin
            mon(0, vga0.p_tick);
            mon(1, vga1.p_tick);
        end
    end

    // One clock: account enabled cycles at the edge, push expected ticks, return at negedge.
    task automatic step();
        @(posedge clk);
        if (rst_n && en) begin
            e_cnt++;
            if (e_cnt % D_DIV == 0) begin
                n_cnt[0]++;
                q0.push_back(ref_model(0, n_cnt[0]));
            end
            if (e_cnt % S_DIV == 0) begin
                n_cnt[1]++;
                q1.push_back(ref_model(1, n_cnt[1]));
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_now();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sample(i) !== reset_obs(i) || (i == 0 ? vga0.p_tick : vga1.p_tick) !== 1'b0) begin
                errors++;
                report("reset_val", i, (i == 0 ? vga0.p_tick : vga1.p_tick), sample(i), reset_obs(i));
            end
        end
    endtask

    task automatic wait_x(input logic [9:0] target, input string name);
        int k;
        k = 0;
        while (!(vga0.p_tick && vga0.pix_x == target) && k < 4000) begin
            step();
            k++;
        end
        if (k >= 4000) begin
            checks++;
            errors++;
            $display("FAIL %s: pix_x=%0d never reached required %0d", name, vga0.pix_x, target);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        e_cnt    = 0;
        n_cnt[0] = 0;
        n_cnt[1] = 0;
        en       = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_now();
        #2 rst_n = 1'b1;

        // Two full lines with sparse random EN drops.
        for (int c = 0; c < 7000; c++) begin
            en = ($urandom_range(0, 15) != 0);
            step();
        end

        en = 1'b1;
        wait_x(10'd300, "wait_x300");
        en = 1'b0;
        repeat (37) step();
        en = 1'b1;
        repeat (40) step();

        wait_x(10'd700, "wait_x700");
        #2 rst_n = 1'b0;
        #1 check_reset_now();
        e_cnt    = 0;
        n_cnt[0] = 0;
        n_cnt[1] = 0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 7) != 0);
            step();
        end
        step();

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: pending expected ticks %0d/%0d, required 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
